// File: rtl/rr_report_pkg.sv
// Shared types and sizing helpers for the R-peak report serialiser.
// Entries are stored at the widest supported field width; narrower counters are zero-extended.
package rr_report_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        RR,
        LOC,
        CSUM
    } rr_tx_state_e;

    localparam int MAX_CTR_WIDTH     = 32;
    localparam int DEFAULT_CTR_WIDTH = 22;

    typedef struct packed {
        logic [7:0]               seq;
        logic [MAX_CTR_WIDTH-1:0] rr;
        logic [MAX_CTR_WIDTH-1:0] loc;
    } rr_entry_t;

    function automatic int field_bytes(input int ctr_width);
        return (ctr_width + 7) / 8;
    endfunction

    function automatic int frame_len(input int ctr_width);
        return 2 * field_bytes(ctr_width) + 3;
    endfunction

    localparam int FRAME_LEN = frame_len(DEFAULT_CTR_WIDTH);

endpackage

// File: rtl/rr_report_fifo.sv
// Single-clock result FIFO with a combinational head (no read latency).
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module rr_report_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    import rr_report_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire, rd_fire;

    assign o_full    = (count_q == LW'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_level   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    always_comb begin
        rd_fire  = i_rd_en && !o_empty;
        wr_fire  = i_wr_en && (!o_full || rd_fire);
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, wr_fire} - {{AW{1'b0}}, rd_fire};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

endmodule

// File: rtl/rr_report_tx.sv
// Frames queued RR period / R-peak location results into SYNC,SEQ,RR,LOC,CSUM byte frames.
// Valid/ready: a byte moves when o_tx_valid && i_tx_ready at a clock edge; data holds while stalled.
module rr_report_tx #(
    parameter int         CTR_WIDTH  = 22,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CTR_WIDTH-1:0]          i_rr_period,
    input  logic                          i_rr_period_updated,
    input  logic [CTR_WIDTH-1:0]          i_rpeak_location,
    input  logic                          i_ovf_clr,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_busy
);
    import rr_report_pkg::*;

    localparam int         NB       = field_bytes(CTR_WIDTH);
    localparam logic [1:0] LAST_IDX = 2'(NB - 1);

    rr_tx_state_e state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    rr_entry_t    frame_q, frame_d;
    logic [7:0]   csum_q, csum_d;
    logic [7:0]   seq_q, seq_d;
    logic         ovf_q, ovf_d;

    rr_entry_t    push_entry, fifo_head;
    logic         fifo_full, fifo_empty, pop, drop;

    assign push_entry = '{seq: seq_q,
                          rr:  MAX_CTR_WIDTH'(i_rr_period),
                          loc: MAX_CTR_WIDTH'(i_rpeak_location)};

    rr_report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rr_entry_t))
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_rr_period_updated),
        .i_wr_data (push_entry),
        .i_rd_en   (pop),
        .o_rd_data (fifo_head),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_level   (o_fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        csum_d     = csum_q;
        pop        = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    frame_d = fifo_head;
                    csum_d  = 8'h00;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                o_tx_valid = 1'b1;
                o_tx_data  = SYNC_BYTE;
                if (i_tx_ready) state_d = SEQ;
            end
            SEQ: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_q.seq;
                if (i_tx_ready) begin
                    csum_d  = csum_q ^ o_tx_data;
                    idx_d   = LAST_IDX;
                    state_d = RR;
                end
            end
            RR: begin
                // Fields go out MSB byte first; idx counts down to byte 0.
                o_tx_valid = 1'b1;
                o_tx_data  = frame_q.rr[{idx_q, 3'b000} +: 8];
                if (i_tx_ready) begin
                    csum_d = csum_q ^ o_tx_data;
                    if (idx_q == 2'd0) begin
                        idx_d   = LAST_IDX;
                        state_d = LOC;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
            end
            LOC: begin
                o_tx_valid = 1'b1;
                o_tx_data  = frame_q.loc[{idx_q, 3'b000} +: 8];
                if (i_tx_ready) begin
                    csum_d = csum_q ^ o_tx_data;
                    if (idx_q == 2'd0) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q - 2'd1;
                    end
                end
            end
            CSUM: begin
                o_tx_valid = 1'b1;
                o_tx_data  = csum_q;
                if (i_tx_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // A pulse on a full FIFO survives only if the FSM frees the head in the same cycle.
        drop  = i_rr_period_updated && fifo_full && !pop;
        seq_d = i_rr_period_updated ? seq_q + 8'd1 : seq_q;
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    assign o_overflow = ovf_q;
    assign o_busy     = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            frame_q <= '0;
            csum_q  <= 8'h00;
            seq_q   <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            csum_q  <= csum_d;
            seq_q   <= seq_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rr_report_tx.sv
// Bench for rr_report_tx: vector table plus hand sequences for timing, overflow and reset,
// with every accepted byte checked against an expected-byte queue.
module tb_rr_report_tx;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [21:0] i_rr_period = '0;
    logic        i_rr_period_updated = 1'b0;
    logic [21:0] i_rpeak_location = '0;
    logic        i_ovf_clr = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_overflow;
    logic [2:0]  o_fifo_level;
    logic        o_busy;

    rr_report_tx dut (
        .i_clk               (clk),
        .i_rst               (i_rst),
        .i_rr_period         (i_rr_period),
        .i_rr_period_updated (i_rr_period_updated),
        .i_rpeak_location    (i_rpeak_location),
        .i_ovf_clr           (i_ovf_clr),
        .o_tx_data           (o_tx_data),
        .o_tx_valid          (o_tx_valid),
        .i_tx_ready          (i_tx_ready),
        .o_overflow          (o_overflow),
        .o_fifo_level        (o_fifo_level),
        .o_busy              (o_busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         ready_mode = 0;   // 0: ready low, 1: ready high, 2: random
    logic [7:0] tb_seq = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [21:0] rr;
        logic [21:0] loc;
        int          mode;
        logic [7:0]  exp_seq;
        logic [7:0]  exp_csum;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_csum(input logic [7:0] s, input logic [21:0] rr,
                                              input logic [21:0] loc);
        logic [23:0] r;
        logic [23:0] l;
        r = {2'b00, rr};
        l = {2'b00, loc};
        return s ^ r[23:16] ^ r[15:8] ^ r[7:0] ^ l[23:16] ^ l[15:8] ^ l[7:0];
    endfunction

    task automatic push_frame(input logic [7:0] s, input logic [21:0] rr, input logic [21:0] loc,
                              input logic [7:0] cs);
        logic [23:0] r;
        logic [23:0] l;
        r = {2'b00, rr};
        l = {2'b00, loc};
        exp_q.push_back(8'hA5);
        exp_q.push_back(s);
        exp_q.push_back(r[23:16]);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(l[23:16]);
        exp_q.push_back(l[15:8]);
        exp_q.push_back(l[7:0]);
        exp_q.push_back(cs);
    endtask

    // Advance to just after the next rising edge and refresh ready.
    task automatic step();
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       i_tx_ready = 1'b0;
            1:       i_tx_ready = 1'b1;
            default: i_tx_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_pulse(input logic [21:0] rr, input logic [21:0] loc, input bit accept,
                             input bit clr);
        i_rr_period         = rr;
        i_rpeak_location    = loc;
        i_rr_period_updated = 1'b1;
        i_ovf_clr           = clr;
        if (accept) push_frame(tb_seq, rr, loc, model_csum(tb_seq, rr, loc));
        tb_seq = tb_seq + 8'd1;
    endtask

    task automatic clear_pulse();
        i_rr_period_updated = 1'b0;
        i_ovf_clr           = 1'b0;
        i_rr_period         = 22'($urandom_range(0, 32'h3FFFFF));
        i_rpeak_location    = 22'($urandom_range(0, 32'h3FFFFF));
    endtask

    task automatic pulse(input logic [21:0] rr, input logic [21:0] loc, input bit accept,
                         input bit clr);
        step();
        set_pulse(rr, loc, accept, clr);
        step();
        clear_pulse();
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            @(negedge clk);
            if (exp_q.size() == 0 && !o_busy) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Byte monitor: scoreboard pops on every handshake; stalled bytes must hold.
    initial begin
        logic       prev_stall;
        logic       prev_rst;
        logic [7:0] prev_data;
        logic [7:0] exp;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!i_rst && !prev_rst && prev_stall) begin
                check("stall_valid", {31'd0, o_tx_valid}, 32'd1);
                check("stall_data", {24'd0, o_tx_data}, {24'd0, prev_data});
            end
            if (!i_rst && o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %h expected none at %0t", o_tx_data, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("tx_byte", {24'd0, o_tx_data}, {24'd0, exp});
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready && !i_rst;
            prev_data  = o_tx_data;
            prev_rst   = i_rst;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lit[9];
        vecs[0] = '{rr: 22'h3FFFFF, loc: 22'h000000, mode: 1, exp_seq: 8'h02, exp_csum: 8'h3D};
        vecs[1] = '{rr: 22'h000000, loc: 22'h000000, mode: 2, exp_seq: 8'h03, exp_csum: 8'h03};
        vecs[2] = '{rr: 22'h123456, loc: 22'h3EDCBA, mode: 1, exp_seq: 8'h04, exp_csum: 8'h2C};
        vecs[3] = '{rr: 22'h000001, loc: 22'h3FFFFF, mode: 2, exp_seq: 8'h05, exp_csum: 8'h3B};
        lit = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hDE, 8'h4A};

        // Reset values
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", {31'd0, o_tx_valid}, 32'd0);
        check("rst_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_ovf", {31'd0, o_overflow}, 32'd0);
        check("rst_level", {29'd0, o_fifo_level}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        step();
        i_rst = 1'b0;

        // Single frame against the literal byte sequence, with pulse-to-SYNC latency
        ready_mode = 1;
        for (int i = 0; i < rr_report_pkg::FRAME_LEN; i++) exp_q.push_back(lit[i]);
        pulse(22'h000123, 22'h0ABCDE, 1'b0, 1'b0);
        @(negedge clk);
        check("lat_level", {29'd0, o_fifo_level}, 32'd1);
        check("lat_valid_n1", {31'd0, o_tx_valid}, 32'd0);
        @(negedge clk);
        check("lat_valid_n2", {31'd0, o_tx_valid}, 32'd1);
        check("lat_sync", {24'd0, o_tx_data}, 32'h0000_00A5);
        wait_drain("single_drain");

        // Same payload under random back-pressure
        ready_mode = 2;
        push_frame(8'h01, 22'h000123, 22'h0ABCDE, 8'h4B);
        pulse(22'h000123, 22'h0ABCDE, 1'b0, 1'b0);
        wait_drain("bp_drain");

        // Vector table
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].mode;
            push_frame(vecs[v].exp_seq, vecs[v].rr, vecs[v].loc, vecs[v].exp_csum);
            pulse(vecs[v].rr, vecs[v].loc, 1'b0, 1'b0);
            wait_drain("vec_drain");
            check("vec_level", {29'd0, o_fifo_level}, 32'd0);
        end

        // Back-to-back frames: CSUM accepted at M, next SYNC valid at M+2
        ready_mode = 1;
        step();
        set_pulse(22'h00BEEF, 22'h001234, 1'b1, 1'b0);
        step();
        set_pulse(22'h2AAAAA, 22'h155555, 1'b1, 1'b0);
        step();
        clear_pulse();
        @(negedge clk);
        check("b2b_sync1", {23'd0, o_tx_valid, o_tx_data}, 32'h0000_01A5);
        repeat (8) @(negedge clk);
        check("b2b_csum_valid", {31'd0, o_tx_valid}, 32'd1);
        @(negedge clk);
        check("b2b_gap", {31'd0, o_tx_valid}, 32'd0);
        @(negedge clk);
        check("b2b_sync2", {23'd0, o_tx_valid, o_tx_data}, 32'h0000_01A5);
        wait_drain("b2b_drain");

        // Overflow: one frame in flight plus four queued, the sixth pulse is dropped
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            pulse(22'(i * 3 + 1), 22'(i * 5 + 2), (i < 5), 1'b0);
        end
        @(negedge clk);
        check("ovf_level", {29'd0, o_fifo_level}, 32'd4);
        check("ovf_flag", {31'd0, o_overflow}, 32'd1);
        pulse(22'h000077, 22'h000088, 1'b0, 1'b1);
        @(negedge clk);
        check("ovf_set_wins", {31'd0, o_overflow}, 32'd1);
        step();
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", {31'd0, o_overflow}, 32'd0);
        ready_mode = 1;
        wait_drain("ovf_drain");
        pulse(22'h000F0F, 22'h00F0F0, 1'b1, 1'b0);
        wait_drain("ovf_next_drain");

        // Full FIFO: pulse lands in the IDLE-load cycle, so push and pop cancel
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            pulse(22'(i + 100), 22'(i + 200), 1'b1, 1'b0);
        end
        @(negedge clk);
        check("full_level", {29'd0, o_fifo_level}, 32'd4);
        ready_mode = 1;
        step();
        repeat (8) step();
        @(negedge clk);
        check("full_csum_phase", {31'd0, o_tx_valid}, 32'd1);
        step();
        set_pulse(22'h030303, 22'h040404, 1'b1, 1'b0);
        @(negedge clk);
        check("full_idle_cycle", {31'd0, o_tx_valid}, 32'd0);
        check("full_level_pre", {29'd0, o_fifo_level}, 32'd4);
        step();
        clear_pulse();
        @(negedge clk);
        check("full_level_post", {29'd0, o_fifo_level}, 32'd4);
        check("full_no_ovf", {31'd0, o_overflow}, 32'd0);
        wait_drain("full_drain");
        check("full_no_ovf_end", {31'd0, o_overflow}, 32'd0);

        // Reset mid-frame, right after the RR bytes
        ready_mode = 1;
        pulse(22'h000123, 22'h0ABCDE, 1'b1, 1'b0);
        repeat (5) step();
        ready_mode = 0;
        step();
        i_rst = 1'b1;
        exp_q.delete();
        tb_seq = 8'h00;
        @(negedge clk);
        check("mid_loc_byte", {23'd0, o_tx_valid, o_tx_data}, 32'h0000_010A);
        step();
        i_rst = 1'b0;
        @(negedge clk);
        check("mid_valid_low", {31'd0, o_tx_valid}, 32'd0);
        check("mid_level", {29'd0, o_fifo_level}, 32'd0);
        check("mid_busy", {31'd0, o_busy}, 32'd0);
        ready_mode = 1;
        pulse(22'h000321, 22'h000654, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_fresh_sync", {23'd0, o_tx_valid, o_tx_data}, 32'h0000_01A5);
        wait_drain("mid_drain");

        // Sequence wrap: 257 spaced pulses take SEQ through FF back to 00
        for (int i = 0; i < 257; i++) begin
            pulse(22'($urandom_range(0, 32'h3FFFFF)), 22'($urandom_range(0, 32'h3FFFFF)), 1'b1, 1'b0);
            repeat (10) step();
        end
        wait_drain("wrap_drain");
        check("wrap_no_ovf", {31'd0, o_overflow}, 32'd0);
        check("wrap_seq_model", {24'd0, tb_seq}, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
